// File: rtl/logic_func_eval.sv
// ---------------------------------------------------------------------------
// logic_func_eval
//   Registered evaluator of an N_IN-input boolean function held as a truth
//   table. The table starts as INIT_TABLE and can be reloaded serially at run
//   time (LSB / entry 0 first). The inputs pass through a stability filter so
//   short glitches never reach the result. Rising edges of the result are
//   flagged and counted in a saturating counter.
//
// Ports
//   clk       in   1      rising-edge clock
//   rstn      in   1      asynchronous active-low reset
//   in_vec    in   N_IN   function inputs, in_vec[N_IN-1] is the MSB
//   cfg_load  in   1      table-load strobe, one cfg_bit consumed per high edge
//   cfg_bit   in   1      serial table bit, entry 0 first
//   cfg_done  out  1      one-cycle pulse when the last table bit is committed
//   clr_cnt   in   1      synchronous clear of hit_cnt (beats an increment)
//   r_out     out  1      registered, filtered function result
//   r_valid   out  1      r_out was computed from the current table
//   r_rise    out  1      one-cycle pulse after each 0->1 step of r_out
//   hit_cnt   out  CNT_W  saturating count of r_rise pulses
// ---------------------------------------------------------------------------
module logic_func_eval #(
  parameter int                       N_IN       = 4,
  parameter logic [(2**N_IN)-1:0]     INIT_TABLE = '0,
  parameter int                       FILT       = 2,
  parameter int                       CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             cfg_load,
  input  logic             cfg_bit,
  output logic             cfg_done,
  input  logic             clr_cnt,
  output logic             r_out,
  output logic             r_valid,
  output logic             r_rise,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int ENTRIES = 2 ** N_IN;
  // FILT=0 still needs a one-bit counter so the vector is never zero width.
  localparam int SW = (FILT > 0) ? $clog2(FILT + 1) : 1;

  typedef enum logic {RUN, LOAD} state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] table_q, table_d;
  logic [ENTRIES-1:0] shadow_q, shadow_d;
  logic [N_IN-1:0]    bit_idx_q, bit_idx_d;
  logic [N_IN-1:0]    in_q, in_d;
  logic [SW-1:0]      stab_q, stab_d;
  logic               r_out_q, r_out_d;
  logic               r_prev_q, r_prev_d;
  logic               r_valid_q, r_valid_d;
  logic               r_rise_q, r_rise_d;
  logic               cfg_done_q, cfg_done_d;
  logic [CNT_W-1:0]   hit_q, hit_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      table_q    <= INIT_TABLE;
      shadow_q   <= INIT_TABLE;
      bit_idx_q  <= '0;
      in_q       <= '0;
      stab_q     <= '0;
      r_out_q    <= 1'b0;
      r_prev_q   <= 1'b0;
      r_valid_q  <= 1'b0;
      r_rise_q   <= 1'b0;
      cfg_done_q <= 1'b0;
      hit_q      <= '0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      shadow_q   <= shadow_d;
      bit_idx_q  <= bit_idx_d;
      in_q       <= in_d;
      stab_q     <= stab_d;
      r_out_q    <= r_out_d;
      r_prev_q   <= r_prev_d;
      r_valid_q  <= r_valid_d;
      r_rise_q   <= r_rise_d;
      cfg_done_q <= cfg_done_d;
      hit_q      <= hit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    shadow_d   = shadow_q;
    bit_idx_d  = bit_idx_q;
    r_out_d    = r_out_q;
    r_valid_d  = r_valid_q;
    r_rise_d   = 1'b0;
    cfg_done_d = 1'b0;
    hit_d      = hit_q;
    r_prev_d   = r_out_q;

    // The filter runs in every state; the count stops at FILT so a long
    // stable period keeps the update condition asserted.
    in_d = in_vec;
    if (in_vec != in_q) begin
      stab_d = '0;
    end else if (stab_q != SW'(FILT)) begin
      stab_d = stab_q + 1'b1;
    end else begin
      stab_d = stab_q;
    end

    case (state_q)
      RUN: begin
        if (cfg_load) begin
          // Entering LOAD already consumes entry 0 and drops r_valid so the
          // result is never flagged valid against a half-written table.
          state_d     = LOAD;
          shadow_d[0] = cfg_bit;
          bit_idx_d   = N_IN'(1);
          r_valid_d   = 1'b0;
        end else begin
          if (stab_q == SW'(FILT)) begin
            r_out_d   = table_q[in_q];
            r_valid_d = 1'b1;
          end
          r_rise_d = r_out_q & ~r_prev_q;
        end
      end
      LOAD: begin
        r_valid_d = 1'b0;
        if (cfg_load) begin
          shadow_d[bit_idx_q] = cfg_bit;
          if (bit_idx_q == N_IN'(ENTRIES - 1)) begin
            // Commit includes the bit written on this very edge, and the
            // filter restarts so the first result comes from the new table.
            table_d    = shadow_d;
            cfg_done_d = 1'b1;
            stab_d     = '0;
            bit_idx_d  = '0;
            state_d    = RUN;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (clr_cnt) begin
      hit_d = '0;
    end else if (r_rise_q && (hit_q != {CNT_W{1'b1}})) begin
      hit_d = hit_q + 1'b1;
    end
  end

  assign cfg_done = cfg_done_q;
  assign r_out    = r_out_q;
  assign r_valid  = r_valid_q;
  assign r_rise   = r_rise_q;
  assign hit_cnt  = hit_q;

endmodule

// File: tb/tb_logic_func_eval.sv
// ---------------------------------------------------------------------------
// tb_logic_func_eval
//   Directed bench for logic_func_eval. Three instances share the clock and
//   reset: the default build, a CNT_W=2 build that follows the same stimulus,
//   and a FILT=0 build with its own input and a preset table.
//   Stimulus pushes expected r_out results, cfg_done pulses and r_rise pulses
//   into queues; a monitor on the falling edge pops them as the DUT presents
//   each event. Timing-sensitive points are checked directly.
// ---------------------------------------------------------------------------
module tb_logic_func_eval;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] inVec;
  logic [3:0] inVec0;
  logic       cfgLoad;
  logic       cfgBit;
  logic       clrCnt;

  logic       cfgDone, rOut, rValid, rRise;
  logic [7:0] hitCnt;
  logic       cfgDone2, rOut2, rValid2, rRise2;
  logic [1:0] hitCnt2;
  logic       cfgDone0, rOut0, rValid0, rRise0;
  logic [7:0] hitCnt0;

  int assertions = 0;
  int failures   = 0;

  bit resQ[$];
  int doneQ[$];
  int riseQ[$];

  always #5 clk = ~clk;

  logic_func_eval dut (
    .clk(clk), .rstn(rstn), .in_vec(inVec), .cfg_load(cfgLoad), .cfg_bit(cfgBit),
    .cfg_done(cfgDone), .clr_cnt(clrCnt), .r_out(rOut), .r_valid(rValid),
    .r_rise(rRise), .hit_cnt(hitCnt)
  );

  logic_func_eval #(.CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_vec(inVec), .cfg_load(cfgLoad), .cfg_bit(cfgBit),
    .cfg_done(cfgDone2), .clr_cnt(clrCnt), .r_out(rOut2), .r_valid(rValid2),
    .r_rise(rRise2), .hit_cnt(hitCnt2)
  );

  logic_func_eval #(.FILT(0), .INIT_TABLE(16'h1080)) dut0 (
    .clk(clk), .rstn(rstn), .in_vec(inVec0), .cfg_load(1'b0), .cfg_bit(1'b0),
    .cfg_done(cfgDone0), .clr_cnt(1'b0), .r_out(rOut0), .r_valid(rValid0),
    .r_rise(rRise0), .hit_cnt(hitCnt0)
  );

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    inVec = v;
  endtask

  // Serial table load; gapAt inserts gapLen idle cycles before that bit,
  // abortAt pulses reset instead of writing that bit.
  task automatic loadTable(input logic [15:0] t, input int gapAt, input int gapLen,
                           input int abortAt);
    if (abortAt < 0) doneQ.push_back(1);
    for (int i = 0; i < 16; i++) begin
      if (i == gapAt) begin
        cfgLoad = 1'b0;
        tick(gapLen);
        checkOutput("valid low during stall", 32'(rValid), 0);
      end
      if (i == abortAt) begin
        cfgLoad = 1'b0;
        #1 rstn = 1'b0;
        #1;
        checkOutput("reset mid-load r_valid", 32'(rValid), 0);
        checkOutput("reset mid-load cfg_done", 32'(cfgDone), 0);
        checkOutput("reset mid-load hit_cnt", 32'(hitCnt), 0);
        rstn = 1'b1;
        return;
      end
      cfgLoad = 1'b1;
      cfgBit  = t[i];
      tick(1);
      if (i == 0)  checkOutput("valid low in load", 32'(rValid), 0);
      if (i == 14) checkOutput("cfg_done before last bit", 32'(cfgDone), 0);
      if (i == 15) checkOutput("cfg_done on last bit", 32'(cfgDone), 1);
    end
    cfgLoad = 1'b0;
  endtask

  // Scoreboard monitor: pops an expectation for each event the DUT presents.
  initial begin
    logic prevValid;
    logic prevOut;
    bit   expBit;
    int   resN;
    prevValid = 1'b0;
    prevOut   = 1'b0;
    resN      = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prevValid = 1'b0;
        prevOut   = 1'b0;
      end else begin
        if (rValid && (!prevValid || rOut != prevOut)) begin
          resN++;
          if (resQ.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL result #%0d: unexpected r_out=%0b, expected no event", resN, rOut);
          end else begin
            expBit = resQ.pop_front();
            checkOutput($sformatf("result #%0d r_out", resN), 32'(rOut), 32'(expBit));
          end
        end
        if (cfgDone) begin
          assertions++;
          if (doneQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL cfg_done pulse: got 1, expected no pulse");
          end else begin
            void'(doneQ.pop_front());
          end
        end
        if (rRise) begin
          assertions++;
          if (riseQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL r_rise pulse: got 1, expected no pulse");
          end else begin
            void'(riseQ.pop_front());
          end
        end
        prevValid = rValid;
        prevOut   = rOut;
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    inVec   = 4'b0000;
    inVec0  = 4'b0000;
    cfgLoad = 1'b0;
    cfgBit  = 1'b0;
    clrCnt  = 1'b0;

    // Reset state
    tick(1);
    checkOutput("reset r_out", 32'(rOut), 0);
    checkOutput("reset r_valid", 32'(rValid), 0);
    checkOutput("reset r_rise", 32'(rRise), 0);
    checkOutput("reset cfg_done", 32'(cfgDone), 0);
    checkOutput("reset hit_cnt", 32'(hitCnt), 0);
    tick(1);

    // Test 1: table all zero, input held, first result after edge 4
    $display("[TB] test 1: first result latency");
    rstn = 1'b1;
    applyStimulus(4'b0111);
    resQ.push_back(1'b0);
    tick(3);
    checkOutput("t1 valid before edge 4", 32'(rValid), 0);
    tick(1);
    checkOutput("t1 valid after edge 4", 32'(rValid), 1);
    checkOutput("t1 r_out", 32'(rOut), 0);
    tick(4);
    checkOutput("t1 hit_cnt", 32'(hitCnt), 0);

    // Test 2: load 16'h1080, then evaluate entries 7, 12 and 2
    $display("[TB] test 2: load and evaluate");
    applyStimulus(4'b0000);
    tick(4);
    loadTable(16'h1080, -1, 0, -1);
    applyStimulus(4'b0111);
    resQ.push_back(1'b1);
    riseQ.push_back(1);
    tick(1);
    checkOutput("t2 cfg_done one cycle", 32'(cfgDone), 0);
    tick(2);
    checkOutput("t2 valid before 4th edge", 32'(rValid), 0);
    tick(1);
    checkOutput("t2 valid after 4th edge", 32'(rValid), 1);
    checkOutput("t2 r_out entry 7", 32'(rOut), 1);
    tick(1);
    checkOutput("t2 r_rise pulse", 32'(rRise), 1);
    tick(1);
    checkOutput("t2 r_rise ends", 32'(rRise), 0);
    checkOutput("t2 hit_cnt", 32'(hitCnt), 1);
    checkOutput("t2 hit_cnt narrow", 32'(hitCnt2), 1);
    applyStimulus(4'b1100);
    tick(6);
    checkOutput("t2 r_out entry 12", 32'(rOut), 1);
    applyStimulus(4'b0010);
    resQ.push_back(1'b0);
    tick(3);
    checkOutput("t2 r_out before filter", 32'(rOut), 1);
    tick(1);
    checkOutput("t2 r_out entry 2", 32'(rOut), 0);

    // Test 3: a one-cycle glitch never reaches r_out
    $display("[TB] test 3: glitch suppression");
    applyStimulus(4'b0111);
    resQ.push_back(1'b1);
    riseQ.push_back(1);
    tick(6);
    checkOutput("t3 hit_cnt before glitch", 32'(hitCnt), 2);
    applyStimulus(4'b0010);
    tick(1);
    applyStimulus(4'b0111);
    tick(6);
    checkOutput("t3 r_out after glitch", 32'(rOut), 1);
    checkOutput("t3 hit_cnt after glitch", 32'(hitCnt), 2);

    // Test 4a: load with a 3-cycle stall mid-stream
    $display("[TB] test 4: stalled load and aborted load");
    applyStimulus(4'b0000);
    resQ.push_back(1'b0);
    tick(6);
    loadTable(16'h1080, 8, 3, -1);
    resQ.push_back(1'b0);
    tick(5);
    applyStimulus(4'b1100);
    resQ.push_back(1'b1);
    riseQ.push_back(1);
    tick(6);
    checkOutput("t4 hit_cnt", 32'(hitCnt), 3);
    applyStimulus(4'b0111);
    tick(6);
    checkOutput("t4 r_out entry 7", 32'(rOut), 1);
    applyStimulus(4'b0000);
    resQ.push_back(1'b0);
    tick(6);

    // Test 4b: reset at bit 9 restores the initial table
    loadTable(16'h1080, -1, 0, 9);
    applyStimulus(4'b1100);
    resQ.push_back(1'b0);
    tick(6);
    checkOutput("t4 table back to init", 32'(rOut), 0);
    checkOutput("t4 valid after reset", 32'(rValid), 1);
    checkOutput("t4 hit_cnt after reset", 32'(hitCnt), 0);
    checkOutput("t4 hit_cnt narrow after reset", 32'(hitCnt2), 0);

    // Test 5: saturation of the narrow counter, clear beats increment
    $display("[TB] test 5: counter saturation and clear");
    applyStimulus(4'b0000);
    tick(6);
    loadTable(16'h1080, -1, 0, -1);
    resQ.push_back(1'b0);
    tick(6);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0111);
      resQ.push_back(1'b1);
      riseQ.push_back(1);
      tick(6);
      applyStimulus(4'b0000);
      resQ.push_back(1'b0);
      tick(6);
    end
    checkOutput("t5 hit_cnt six rises", 32'(hitCnt), 6);
    checkOutput("t5 hit_cnt narrow saturated", 32'(hitCnt2), 3);
    applyStimulus(4'b0111);
    resQ.push_back(1'b1);
    riseQ.push_back(1);
    tick(5);
    checkOutput("t5 r_rise before clear", 32'(rRise), 1);
    clrCnt = 1'b1;
    tick(1);
    clrCnt = 1'b0;
    checkOutput("t5 clear wins", 32'(hitCnt), 0);
    checkOutput("t5 clear wins narrow", 32'(hitCnt2), 0);
    tick(3);
    checkOutput("t5 hit_cnt stays clear", 32'(hitCnt), 0);
    applyStimulus(4'b0000);
    resQ.push_back(1'b0);
    tick(6);

    // Test 6: FILT=0 instance follows the input two edges after each change
    $display("[TB] test 6: zero filter");
    inVec0 = 4'b0111;
    tick(1);
    checkOutput("t6 r_out edge 1", 32'(rOut0), 0);
    tick(1);
    checkOutput("t6 r_out edge 2", 32'(rOut0), 1);
    inVec0 = 4'b1100;
    tick(1);
    checkOutput("t6 no gap edge 1", 32'(rOut0), 1);
    tick(1);
    checkOutput("t6 no gap edge 2", 32'(rOut0), 1);
    inVec0 = 4'b0010;
    tick(1);
    checkOutput("t6 fall edge 1", 32'(rOut0), 1);
    tick(1);
    checkOutput("t6 fall edge 2", 32'(rOut0), 0);

    // Everything expected must have been presented by now
    tick(4);
    checkOutput("pending results", 32'(resQ.size()), 0);
    checkOutput("pending cfg_done", 32'(doneQ.size()), 0);
    checkOutput("pending r_rise", 32'(riseQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
